// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester IDs
// and the word-alignment rule.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Only whole-word accesses reach the memory.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester's link to the memory-port arbiter: request channel plus a
// fixed-latency response strobe.
interface mem_port_arbiter_if #(
    parameter int N = 32
);
    // Handshake: a request transfers on a cycle where valid & ready are both 1.
    // ready may depend combinationally on valid. The response arrives exactly
    // one cycle after the transfer as a single-cycle rsp_valid strobe that the
    // requester must consume then; there is no response back-pressure.
    logic         valid;
    logic         ready;
    logic         we;
    logic         lock;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         rsp_valid;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;

    modport master (
        output valid, we, lock, addr, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, we, lock, addr, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter with an exclusive-lock override.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       lock_active,
    input  logic       lock_owner,
    output logic [1:0] grant_onehot,
    output logic       grant_id
);

    always_comb begin
        grant_onehot = 2'b00;
        grant_id     = REQ_CPU;
        if (lock_active) begin
            // The other requester stays blocked even while the owner is idle.
            if (valid[lock_owner]) begin
                grant_id     = lock_owner;
                grant_onehot = (lock_owner == REQ_DBG) ? 2'b10 : 2'b01;
            end
        end else begin
            case (valid)
                2'b01: begin
                    grant_id     = REQ_CPU;
                    grant_onehot = 2'b01;
                end
                2'b10: begin
                    grant_id     = REQ_DBG;
                    grant_onehot = 2'b10;
                end
                2'b11: begin
                    grant_id     = ~last_grant;
                    grant_onehot = (last_grant == REQ_DBG) ? 2'b01 : 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one port of the CPU dual-port memory between the load/store unit
// (requester 0) and the debug/IO loader (requester 1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int   N            = 32,
    parameter logic DEFAULT_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rstb,
    mem_port_arbiter_if.slave req0,
    mem_port_arbiter_if.slave req1,
    output logic              mem_wr_ena,
    output logic [N-1:0]      mem_addr,
    output logic [N-1:0]      mem_din,
    input  logic [N-1:0]      mem_dout,
    output arb_state_t        dbg_state
);

    arb_state_t   state;
    logic         last_grant;
    logic         lock_active;
    logic         lock_owner;
    logic         rsp_owner;
    logic         rsp_is_read;
    logic         rsp_err_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] din_q;

    logic [1:0]   grant_onehot;
    logic         grant_id;
    logic         accept;
    logic         sel_we;
    logic         sel_lock;
    logic         sel_aligned;
    logic [N-1:0] sel_addr;
    logic [N-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .valid        ({req1.valid, req0.valid}),
        .last_grant   (last_grant),
        .lock_active  (lock_active),
        .lock_owner   (lock_owner),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    assign req0.ready = grant_onehot[0];
    assign req1.ready = grant_onehot[1];
    assign accept     = |grant_onehot;

    assign sel_we      = (grant_id == REQ_DBG) ? req1.we    : req0.we;
    assign sel_lock    = (grant_id == REQ_DBG) ? req1.lock  : req0.lock;
    assign sel_addr    = (grant_id == REQ_DBG) ? req1.addr  : req0.addr;
    assign sel_wdata   = (grant_id == REQ_DBG) ? req1.wdata : req0.wdata;
    assign sel_aligned = is_aligned(sel_addr[1:0]);

    // Address/data hold their last value between transfers; the write enable is
    // gated by rstb so a reset landing on a write cycle never corrupts memory.
    assign mem_addr   = accept ? sel_addr  : addr_q;
    assign mem_din    = accept ? sel_wdata : din_q;
    assign mem_wr_ena = rstb & accept & sel_we & sel_aligned;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            last_grant  <= DEFAULT_LAST;
            lock_active <= 1'b0;
            lock_owner  <= REQ_CPU;
            rsp_owner   <= REQ_CPU;
            rsp_is_read <= 1'b0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
            if (accept) begin
                state       <= RESP;
                last_grant  <= grant_id;
                rsp_owner   <= grant_id;
                rsp_is_read <= ~sel_we;
                rsp_err_q   <= ~sel_aligned;
                lock_active <= sel_lock;
                lock_owner  <= grant_id;
            end else begin
                state <= IDLE;
            end
        end
    end

    logic         rsp_hit0;
    logic         rsp_hit1;
    logic [N-1:0] rsp_data;

    // Memory read data lands one cycle after the address, i.e. in the RESP cycle.
    assign rsp_hit0 = (state == RESP) && (rsp_owner == REQ_CPU);
    assign rsp_hit1 = (state == RESP) && (rsp_owner == REQ_DBG);
    assign rsp_data = (rsp_is_read && !rsp_err_q) ? mem_dout : '0;

    assign req0.rsp_valid = rsp_hit0;
    assign req0.rsp_rdata = rsp_hit0 ? rsp_data : '0;
    assign req0.rsp_err   = rsp_hit0 & rsp_err_q;
    assign req1.rsp_valid = rsp_hit1;
    assign req1.rsp_rdata = rsp_hit1 ? rsp_data : '0;
    assign req1.rsp_err   = rsp_hit1 & rsp_err_q;

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all judged by a transaction-level model of arbitration, lock and memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int   N        = 32;
  localparam logic DEF_LAST = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N(N)) r0_if ();
  mem_port_arbiter_if #(.N(N)) r1_if ();

  logic         mem_wr_ena;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_din;
  logic [N-1:0] mem_dout;
  arb_state_t   dbg_state;

  mem_port_arbiter #(.N(N), .DEFAULT_LAST(DEF_LAST)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req0       (r0_if),
    .req1       (r1_if),
    .mem_wr_ena (mem_wr_ena),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .dbg_state  (dbg_state)
  );

  // Synchronous single-port memory: dout shows the word addressed last cycle.
  logic [N-1:0] phys_mem [logic [29:0]];
  always @(posedge clk) begin
    mem_dout <= phys_mem.exists(mem_addr[31:2]) ? phys_mem[mem_addr[31:2]] : '0;
    if (mem_wr_ena) phys_mem[mem_addr[31:2]] = mem_din;
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic         m_last;
  logic         m_lock;
  logic         m_lock_owner;
  logic         m_addr_known;
  logic [N-1:0] m_addr;
  logic [N-1:0] m_din;
  logic [N-1:0] ref_mem [logic [29:0]];
  logic [N+1:0] exp_q[$];  // {requester, err, rdata}

  logic         s_ready0, s_ready1, s_wr;
  logic         s_rsp0_valid, s_rsp0_err, s_rsp1_valid, s_rsp1_err;
  logic [N-1:0] s_rsp0_rdata, s_rsp1_rdata;
  arb_state_t   s_state;

  task automatic check(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [N-1:0] ref_read(input logic [N-1:0] a);
    return ref_mem.exists(a / 4) ? ref_mem[a / 4] : '0;
  endfunction

  // One clock: sample mid-cycle, compare with the model, then advance.
  task automatic tick();
    logic         has_exp;
    logic [N+1:0] e;
    int           win;
    logic         we, lk, aligned;
    logic [N-1:0] a, d;
    @(negedge clk);
    #1;
    s_ready0 = r0_if.ready;      s_ready1 = r1_if.ready;   s_wr = mem_wr_ena;
    s_rsp0_valid = r0_if.rsp_valid; s_rsp0_rdata = r0_if.rsp_rdata; s_rsp0_err = r0_if.rsp_err;
    s_rsp1_valid = r1_if.rsp_valid; s_rsp1_rdata = r1_if.rsp_rdata; s_rsp1_err = r1_if.rsp_err;
    s_state = dbg_state;
    if (!rstb) begin
      check("wr_ena_in_reset", N'(mem_wr_ena), N'(0));
      @(posedge clk);
      m_last = DEF_LAST; m_lock = 1'b0; m_lock_owner = 1'b0; m_addr_known = 1'b0;
      exp_q.delete();
      #1;
      return;
    end
    has_exp = (exp_q.size() > 0);
    e = has_exp ? exp_q.pop_front() : '0;
    check("state", N'(s_state), has_exp ? N'(RESP) : N'(IDLE));
    check("rsp0_valid", N'(s_rsp0_valid), N'(has_exp && !e[N+1]));
    check("rsp0_rdata", s_rsp0_rdata, (has_exp && !e[N+1]) ? e[N-1:0] : '0);
    check("rsp0_err",   N'(s_rsp0_err), N'(has_exp && !e[N+1] && e[N]));
    check("rsp1_valid", N'(s_rsp1_valid), N'(has_exp && e[N+1]));
    check("rsp1_rdata", s_rsp1_rdata, (has_exp && e[N+1]) ? e[N-1:0] : '0);
    check("rsp1_err",   N'(s_rsp1_err), N'(has_exp && e[N+1] && e[N]));

    win = -1;
    if (m_lock) begin
      if (m_lock_owner ? r1_if.valid : r0_if.valid) win = int'(m_lock_owner);
    end else if (r0_if.valid && r1_if.valid) win = m_last ? 0 : 1;
    else if (r0_if.valid) win = 0;
    else if (r1_if.valid) win = 1;
    check("ready0", N'(s_ready0), N'(win == 0));
    check("ready1", N'(s_ready1), N'(win == 1));

    if (win >= 0) begin
      we = (win == 1) ? r1_if.we    : r0_if.we;
      lk = (win == 1) ? r1_if.lock  : r0_if.lock;
      a  = (win == 1) ? r1_if.addr  : r0_if.addr;
      d  = (win == 1) ? r1_if.wdata : r0_if.wdata;
      aligned = (a % 4 == 0);
      check("wr_ena", N'(s_wr), N'(we && aligned));
      check("mem_addr", mem_addr, a);
      check("mem_din", mem_din, d);
      exp_q.push_back({win[0], !aligned, (!we && aligned) ? ref_read(a) : N'(0)});
      if (we && aligned) ref_mem[a / 4] = d;
      m_last = win[0]; m_lock = lk; m_lock_owner = win[0];
      m_addr = a; m_din = d; m_addr_known = 1'b1;
    end else begin
      check("wr_ena_idle", N'(s_wr), N'(0));
      if (m_addr_known) begin
        check("mem_addr_hold", mem_addr, m_addr);
        check("mem_din_hold", mem_din, m_din);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set0(input logic v, input logic we, input logic lk, input logic [N-1:0] a, input logic [N-1:0] d);
    r0_if.valid = v; r0_if.we = we; r0_if.lock = lk; r0_if.addr = a; r0_if.wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic lk, input logic [N-1:0] a, input logic [N-1:0] d);
    r1_if.valid = v; r1_if.we = we; r1_if.lock = lk; r1_if.addr = a; r1_if.wdata = d;
  endtask

  function automatic logic [N-1:0] rand_addr();
    logic [N-1:0] a;
    a = N'($urandom_range(0, 7)) << 2;
    if ($urandom_range(0, 5) == 0) a = a | N'($urandom_range(1, 3));
    if ($urandom_range(0, 3) == 0) a = a | 32'h4000_0000;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rstb = 1'b0;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    tick(); tick();
    rstb = 1'b1;

    // Reset state
    tick();
    check("rst_state", N'(s_state), N'(IDLE));
    check("rst_rsp_valid", N'({s_rsp1_valid, s_rsp0_valid}), N'(0));

    // Write, read-back, back-to-back read by requester 1
    set0(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    check("wr_ready0", N'(s_ready0), N'(1));
    check("wr_ena_write", N'(s_wr), N'(1));
    set0(1, 0, 0, 32'h0000_0010, '0);
    tick();
    check("wr_rsp_valid", N'(s_rsp0_valid), N'(1));
    check("wr_rsp_err", N'(s_rsp0_err), N'(0));
    check("wr_rsp_rdata", s_rsp0_rdata, '0);
    set0(0, 0, 0, '0, '0);
    set1(1, 0, 0, 32'h4000_0000, '0);
    tick();
    check("rd_rdata", s_rsp0_rdata, 32'hDEAD_BEEF);
    check("b2b_ready1", N'(s_ready1), N'(1));
    set1(0, 0, 0, '0, '0);
    tick();
    check("b2b_rsp1_valid", N'(s_rsp1_valid), N'(1));

    // Round-robin alternation right after reset
    rstb = 1'b0; tick(); rstb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set0(1, 0, 0, N'(k * 4), '0);
      set1(1, 0, 0, N'(32 + k * 4), '0);
      tick();
      check("rr_ready0", N'(s_ready0), N'(k % 2 == 0));
      check("rr_ready1", N'(s_ready1), N'(k % 2 == 1));
    end
    set0(0, 0, 0, '0, '0); set1(0, 0, 0, '0, '0);
    tick();

    // Lock held by requester 1
    set1(1, 0, 1, 32'h0000_0020, '0);
    tick();
    check("lock_take", N'(s_ready1), N'(1));
    set0(1, 0, 0, 32'h0000_0010, '0);
    tick();
    check("lock_block0_a", N'(s_ready0), N'(0));
    set1(0, 0, 1, '0, '0);
    tick();
    check("lock_block0_idle_owner", N'(s_ready0), N'(0));
    set1(1, 0, 0, 32'h0000_0024, '0);
    tick();
    check("lock_block0_release", N'(s_ready0), N'(0));
    check("lock_release_ready1", N'(s_ready1), N'(1));
    set1(0, 0, 0, '0, '0);
    tick();
    check("after_release_ready0", N'(s_ready0), N'(1));
    set0(0, 0, 0, '0, '0);
    tick();

    // Misaligned write and read
    set0(1, 1, 0, 32'h0000_0012, 32'h1234_5678);
    tick();
    check("mis_wr_ready", N'(s_ready0), N'(1));
    check("mis_wr_ena", N'(s_wr), N'(0));
    set0(1, 0, 0, 32'h0000_0010, '0);
    tick();
    check("mis_wr_err", N'(s_rsp0_err), N'(1));
    check("mis_wr_rdata", s_rsp0_rdata, '0);
    set0(1, 0, 0, 32'h0000_0011, '0);
    tick();
    check("mis_unchanged", s_rsp0_rdata, 32'hDEAD_BEEF);
    set0(0, 0, 0, '0, '0);
    tick();
    check("mis_rd_err", N'(s_rsp0_err), N'(1));
    check("mis_rd_rdata", s_rsp0_rdata, '0);

    // Reset during a locked RESP cycle
    set1(1, 0, 1, 32'h0000_0010, '0);
    tick();
    check("rst_lock_take", N'(s_ready1), N'(1));
    set1(0, 0, 1, '0, '0);
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    set1(0, 0, 0, '0, '0);
    tick();
    check("rst_no_rsp", N'({s_rsp1_valid, s_rsp0_valid}), N'(0));
    set0(1, 0, 0, 32'h0000_0004, '0);
    set1(1, 0, 0, 32'h0000_0008, '0);
    tick();
    check("rst_tie_ready0", N'(s_ready0), N'(1));
    check("rst_tie_ready1", N'(s_ready1), N'(0));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rstb = ($urandom_range(0, 99) != 0);
      set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           rand_addr(), N'($urandom));
      set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           rand_addr(), N'($urandom));
      tick();
    end
    rstb = 1'b1;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single port (addr/din/wr_ena/dout) of the CPU's dual-port memory between two requesters. Requester 0 is the CPU load/store unit; requester 1 is the debug/IO loader.
- Round-robin arbitration, with an optional lock for atomic multi-word sequences.
- Valid/ready request handshake; fixed one-cycle response.
- Misaligned accesses are blocked and reported as errors.

Parameters:
N, 32, data/address bus width
DEFAULT_LAST, 1, last_grant value after reset (1 means requester 0 wins the first tie)

Ports:
clk  input  1  rising-edge clock
rstb  input  1  synchronous active-low reset; one clock; sampled on posedge clk
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0's request accepted this cycle
req0_we  input  1  1 = write, 0 = read
req0_lock  input  1  keep exclusive grant after this transaction
req0_addr  input  N  byte address
req0_wdata  input  N  write data
rsp0_valid  output  1  one-cycle response strobe
rsp0_rdata  output  N  read data (0 for writes and errors)
rsp0_err  output  1  misaligned access
req1_* / rsp1_*  same set as requester 0
mem_wr_ena  output  1  to memory wr_ena
mem_addr  output  N  to memory addr
mem_din  output  N  to memory din
mem_dout  input  N  from memory dout; valid the cycle after the address is presented

Behaviour:
- Reset (rstb=0 at a posedge):
  - state=IDLE, last_grant=DEFAULT_LAST, lock_active=0, rsp_owner=0.
  - rsp0_valid=rsp1_valid=0, rsp*_rdata=0, rsp*_err=0.
  - Any pending response is discarded.
  - mem_wr_ena is combinationally forced to 0 while rstb=0, so reset mid-write never writes memory.
- Arbitration (combinational, every cycle):
  - If lock_active: only lock_owner is eligible.
  - Otherwise, if exactly one req*_valid, that requester wins.
  - If both are valid, the requester != last_grant wins.
  - reqX_ready=1 only for the winner; there is at most one ready per cycle.
- Acceptance (reqX_valid & reqX_ready):
  - mem_addr=reqX_addr and mem_din=reqX_wdata that same cycle.
  - mem_wr_ena=reqX_we & aligned, where aligned = (reqX_addr[1:0]==2'b00).
  - Registers: last_grant<=X, rsp_owner<=X, rsp_is_read<=~we, rsp_err_q<=~aligned.
  - lock_active<=reqX_lock, lock_owner<=X.
  - state<=RESP.
- No acceptance: mem_wr_ena=0. mem_addr/mem_din hold the last driven values (they are registered mirrors, muxed by the grant).
- FSM:
  - IDLE: no response pending.
  - RESP: in this cycle rspY_valid=1 for Y=rsp_owner only, for exactly one cycle.
    - rspY_rdata = mem_dout if rsp_is_read & ~rsp_err_q, else 0.
    - rspY_err = rsp_err_q.
  - A new request may be accepted during RESP, so throughput is 1 transaction/cycle and latency is 1 cycle.
  - Transitions: next state = RESP if a request is accepted this cycle, else IDLE.
- Responses are not back-pressured; requesters must consume rsp in the strobe cycle.
- Lock:
  - Holds while the owner issues locked transactions.
  - Released by an accepted transaction of the owner with lock=0.
  - While locked, the other requester's ready=0 even if the owner is idle.
- Misaligned access: no memory write; a misaligned read returns rdata=0, err=1.
- A read accepted in the same cycle as the other requester's write cannot occur: there is a single grant.
- Holding a request for the instruction-space address range needs no special handling; the memory decodes it.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE=1'b0, RESP=1'b1;
  - requester IDs REQ_CPU=1'b0, REQ_DBG=1'b1;
  - ALIGN_MASK=2'b11.
- Sub-module rr_arb2 (combinational 2-way round-robin):
  - inputs: valid[1:0], last_grant, lock_active, lock_owner;
  - outputs: grant_onehot[1:0], grant_id.

Test Plan:
- Reset, then req0 write addr 0x0000_0010 data 0xDEAD_BEEF → req0_ready=1 same cycle, mem_wr_ena=1; next cycle rsp0_valid=1, rsp0_err=0, rsp0_rdata=0.
- req0 read addr 0x0000_0010 → next cycle rsp0_rdata=0xDEAD_BEEF; req1 back-to-back read of 0x4000_0000 accepted in the RESP cycle → rsp1 valid the following cycle.
- Both valid for 4 cycles after reset → grants alternate 0,1,0,1; exactly one ready per cycle.
- req1 lock=1 for 3 reads while req0 stays valid → req0_ready=0 for 3 cycles; req1 final lock=0 read → req0 granted next cycle.
- req0 write addr 0x0000_0012 → mem_wr_ena=0; next cycle rsp0_err=1, rsp0_rdata=0; memory word 0x10 is unchanged on readback.
- rstb=0 during a RESP cycle with req1 locked → no rsp strobe the next cycle, lock cleared; after release, simultaneous requests are granted to requester 0 first.
